// File: rtl/rv64i_state_dump.sv
// Architectural state dump engine: reads x0..x31 from the register file and
// streams them, followed by a PC snapshot, as 33 ready/valid beats.
module rv64i_state_dump #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] pc_in,
    output logic            core_halt,
    output logic            rf_re,
    output logic [4:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [5:0]      out_idx,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [5:0] PC_IDX = 6'd32;

    state_t          state_reg;
    logic [5:0]      idx_reg;
    logic [XLEN-1:0] pc_snap_reg;
    logic [XLEN-1:0] out_data_reg;
    logic            out_valid_reg;
    logic            out_last_reg;
    logic            rf_re_reg;
    logic [4:0]      rf_raddr_reg;
    logic            busy_reg;
    logic            done_reg;

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_idx   = idx_reg;
    assign rf_re     = rf_re_reg;
    assign rf_raddr  = rf_raddr_reg;
    assign busy      = busy_reg;
    assign core_halt = busy_reg;
    assign done      = done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            pc_snap_reg   <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            rf_re_reg     <= 1'b0;
            rf_raddr_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        pc_snap_reg  <= pc_in;
                        idx_reg      <= '0;
                        rf_re_reg    <= 1'b1;
                        rf_raddr_reg <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= REQ;
                    end
                end
                REQ: begin
                    // The read strobe is raised on entry so it is registered while in REQ.
                    rf_re_reg <= 1'b0;
                    if (idx_reg == PC_IDX) begin
                        out_data_reg  <= pc_snap_reg;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= 1'b1;
                        state_reg     <= SEND;
                    end else begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    // x0 is hardwired zero whatever the register file returns.
                    out_data_reg  <= (idx_reg == 6'd0) ? '0 : rf_rdata;
                    out_valid_reg <= 1'b1;
                    state_reg     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        if (idx_reg == PC_IDX) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            idx_reg   <= idx_reg + 6'd1;
                            state_reg <= REQ;
                            if (idx_reg != 6'd31) begin
                                rf_re_reg    <= 1'b1;
                                rf_raddr_reg <= idx_reg[4:0] + 5'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv64i_state_dump.sv
// Directed bench for rv64i_state_dump: full dumps with x0 masking, a stall,
// ignored restarts, and a mid-dump reset abort.
module tb_rv64i_state_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] pc_in;
    logic        core_halt;
    logic        rf_re;
    logic [4:0]  rf_raddr;
    logic [63:0] rf_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks_cnt = 0;
    int errors_cnt = 0;

    rv64i_state_dump #(.XLEN(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pc_in     (pc_in),
        .core_halt (core_halt),
        .rf_re     (rf_re),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Register file model: xN = N*0x1111, except address 0 returns junk.
    always @(posedge clk) begin
        if (rf_re)
            rf_rdata <= (rf_raddr == 5'd0) ? 64'hDEAD : ({59'd0, rf_raddr} * 64'h1111);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] exp_data(input int i);
        if (i == 0)  return 64'd0;
        if (i == 32) return 64'h8000_0000;
        return 64'(i) * 64'h1111;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      {63'd0, busy},      64'd0);
        check({tag, "_halt"},      {63'd0, core_halt}, 64'd0);
        check({tag, "_valid"},     {63'd0, out_valid}, 64'd0);
        check({tag, "_last"},      {63'd0, out_last},  64'd0);
        check({tag, "_done"},      {63'd0, done},      64'd0);
        check({tag, "_rf_re"},     {63'd0, rf_re},     64'd0);
        check({tag, "_rf_raddr"},  {59'd0, rf_raddr},  64'd0);
        check({tag, "_out_data"},  out_data,           64'd0);
        check({tag, "_out_idx"},   {58'd0, out_idx},   64'd0);
    endtask

    // Start a dump and follow it beat by beat; -1 disables an option.
    task automatic run_dump(input int stall_idx, input int poke_idx, input int abort_idx,
                            input bit start_in_done);
        int cyc = 0;
        int beats = 0;
        int dones = 0;
        int done_cyc = -1;
        int first_valid = -1;
        int stall_left = 5;
        bit poked = 0;
        bit aborted = 0;
        logic [63:0] hold_data = '0;
        logic [5:0]  hold_idx = '0;

        pc_in = 64'h8000_0000;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        check("busy_after_start", {63'd0, busy}, 64'd1);
        check("halt_after_start", {63'd0, core_halt}, 64'd1);
        while (cyc < 400) begin
            start = 1'b0;
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check("done_width", {63'd0, done}, 64'd0);
                check("busy_idle", {63'd0, busy}, 64'd0);
                check("halt_idle", {63'd0, core_halt}, 64'd0);
                break;
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
                if (start_in_done) start = 1'b1;
            end
            if (rf_re) check("rf_raddr", {59'd0, rf_raddr}, 64'(beats));
            out_ready = 1'b1;
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (int'(out_idx) == abort_idx) begin
                    rst_n = 1'b0;
                    #1;
                    check_all_zero("abort");
                    for (int k = 0; k < 3; k++) begin
                        tick();
                        check("abort_no_done", {63'd0, done}, 64'd0);
                    end
                    aborted = 1;
                    break;
                end
                if (int'(out_idx) == stall_idx && stall_left > 0) begin
                    if (stall_left == 5) begin
                        hold_data = out_data;
                        hold_idx = out_idx;
                        check("stall_data", out_data, exp_data(stall_idx));
                    end else begin
                        check("stall_hold_data", out_data, hold_data);
                        check("stall_hold_idx", {58'd0, out_idx}, {58'd0, hold_idx});
                        check("stall_hold_valid", {63'd0, out_valid}, 64'd1);
                    end
                    check("stall_no_rf_re", {63'd0, rf_re}, 64'd0);
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    check("beat_idx", {58'd0, out_idx}, 64'(beats));
                    check("beat_data", out_data, exp_data(beats));
                    check("beat_last", {63'd0, out_last}, (beats == 32) ? 64'd1 : 64'd0);
                    $display("beat idx=%0d data=0x%0h last=%0b cyc=%0d", out_idx, out_data, out_last, cyc);
                    beats++;
                end
                if (int'(out_idx) == poke_idx && !poked) begin
                    start = 1'b1;
                    pc_in = 64'h1234;
                    poked = 1;
                end
            end
            tick();
            cyc++;
        end
        if (!aborted) begin
            check("beat_count", 64'(beats), 64'd33);
            check("done_count", 64'(dones), 64'd1);
            check("first_valid_cyc", 64'(first_valid), 64'd2);
            check("done_cyc", 64'(done_cyc), (stall_idx >= 0) ? 64'd103 : 64'd98);
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        pc_in = 64'h8000_0000;
        out_ready = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        $display("dump 1: plain full dump");
        run_dump(-1, -1, -1, 1'b0);
        tick();

        $display("dump 2: stall on beat 7");
        run_dump(7, -1, -1, 1'b0);
        tick();

        $display("dump 3: restart at beat 10, start in DONE cycle");
        run_dump(-1, 10, -1, 1'b1);
        tick();

        $display("dump 4: reset during beat 15");
        run_dump(-1, -1, 15, 1'b0);
        rst_n = 1'b1;

        $display("dump 5: full dump after reset");
        run_dump(-1, -1, -1, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
